lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

- Hardware sequencer for the board's HD44780-compatible character LCD.
- Accepts byte-wide command/data writes from the core's LCD I/O path over a valid/ready handshake.
- Generates the bus cycles with correct setup, enable-pulse, hold and execution-wait timing, so software no longer bit-bangs the LCD pins.
- After reset it runs the LCD power-on initialisation sequence autonomously, then serves requests.

## Interface

Parameters:
- PWR_CYC, 750000: power-on wait before the first init command.
- SETUP_CYC, 4: RS/DATA setup time before EN rises, in cycles.
- EN_CYC, 12: EN high time, in cycles.
- HOLD_CYC, 4: RS/DATA hold time after EN falls, in cycles.
- CMD_WAIT_CYC, 2000: execution wait for ordinary commands and data.
- CLEAR_WAIT_CYC, 80000: execution wait for clear/home commands.
- All parameters are integers ≥ 1.

Ports:
- i_clk, in, 1: the single clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_req_vld, in, 1: write request valid.
- i_req_rs, in, 1: 0 = instruction, 1 = data.
- i_req_data, in, 8: byte to write.
- o_req_rdy, out, 1: request accepted when high together with i_req_vld.
- o_init_done, out, 1: init sequence complete; sticky until reset.
- o_lcd_on, out, 1: LCD power/backlight enable.
- o_lcd_en, out, 1: LCD EN pin.
- o_lcd_rs, out, 1: LCD RS pin.
- o_lcd_rw, out, 1: LCD RW pin; constant 0 (write-only).
- o_lcd_data, out, 8: LCD DB[7:0].

## Operation

- FSM states: PWR_WAIT, SETUP, EN_HI, HOLD, WAIT, IDLE.
- One shared down-counter, sized to $clog2(max parameter + 1). An init index, 3 bits, walks the init ROM.
- Init ROM, issued in order with RS = 0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- PWR_WAIT:
  - Count PWR_CYC cycles.
  - On exit, set o_lcd_on = 1 and load ROM[0] into the output registers.
  - Go to SETUP.
- SETUP: EN = 0, RS/DATA stable, for SETUP_CYC cycles, then go to EN_HI.
- EN_HI: EN = 1 for EN_CYC cycles, then go to HOLD.
- HOLD: EN = 0, RS/DATA unchanged, for HOLD_CYC cycles, then go to WAIT.
- WAIT length:
  - CLEAR_WAIT_CYC if the latched byte has RS = 0 and DATA ∈ {0x01, 0x02, 0x03}.
  - CMD_WAIT_CYC otherwise.
- WAIT exit:
  - During init with entries remaining: load the next ROM entry and go to SETUP.
  - Otherwise: go to IDLE and set o_init_done = 1.
- IDLE:
  - o_req_rdy = 1.
  - On i_req_vld, latch i_req_rs/i_req_data into o_lcd_rs/o_lcd_data and go to SETUP.
- o_req_rdy is 0 in every state except IDLE. Requests during init or during a transfer are not accepted. The requester holds them (standard valid/ready; vld must not drop before accept).
- o_lcd_rs and o_lcd_data change only on a load (init step or accept). They hold their value through IDLE.
- No request buffering: at most one transfer is in flight.

## Timing

- Reset values:
  - o_req_rdy = 0, o_init_done = 0, o_lcd_on = 0, o_lcd_en = 0, o_lcd_rs = 0, o_lcd_rw = 0, o_lcd_data = 0x00.
  - FSM = PWR_WAIT, counter loaded with PWR_CYC, init index = 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Accept happens on the edge where vld & rdy. From the next cycle:
  - SETUP_CYC cycles with EN low,
  - EN_CYC cycles with EN high,
  - HOLD_CYC cycles with EN low,
  - W cycles of wait, where W is the selected wait length,
  - then o_req_rdy = 1.
  - Accept-to-ready latency is S + E + H + W + 1 cycles.
- Init timing:
  - o_lcd_on rises PWR_CYC cycles after reset release.
  - The first EN rise is SETUP_CYC cycles after o_lcd_on rises.
  - o_init_done and o_req_rdy rise in the same cycle, after the 6th transfer's wait completes.
- Back-to-back requests: the earliest next accept is the cycle rdy returns. There is no dead cycle beyond that.
- Asynchronous reset mid-transfer: EN drops immediately and the full init sequence restarts from PWR_WAIT. A partially pulsed EN is acceptable to the LCD because init follows.

## Test plan

Bench parameters: PWR_CYC = 20, SETUP_CYC = 2, EN_CYC = 4, HOLD_CYC = 2, CMD_WAIT_CYC = 8, CLEAR_WAIT_CYC = 30.

- **Reset and init.** Release reset, then:
  - o_lcd_on rises 20 cycles after release.
  - Exactly 6 EN pulses occur, each 4 cycles wide, carrying data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS = 0.
  - The gap after the 0x01 pulse is at least 30 + 2 cycles.
  - o_init_done and o_req_rdy rise together.
- **Data write.** After init, drive vld, rs = 1, data = 0x41 for one accept. Required:
  - EN high 4 cycles, starting 2 cycles after accept.
  - RS = 1 and DATA = 0x41 stable from 2 cycles before EN rises through 2 cycles after it falls.
  - rdy returns 17 cycles after accept.
- **Clear wait.** Write rs = 0, data = 0x01 -> rdy returns 2 + 4 + 2 + 30 + 1 = 39 cycles after accept. Writing rs = 1, data = 0x01 instead uses the 8-cycle wait (17 cycles).
- **Back-to-back and backpressure.** Hold vld high with 0x48 then 0x49 -> exactly two EN pulses, no accept while rdy = 0, second accept in the cycle rdy returns. A request asserted during init is not taken until o_init_done.
- **Reset mid-pulse.** Assert i_rst_n low during EN_HI -> o_lcd_en, o_lcd_on, o_req_rdy and o_init_done go to 0 immediately. After release, the full 6-command init repeats.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus sequencer: runs the power-on init sequence after reset,
// then turns each accepted byte into a timed setup / EN pulse / hold / execution-wait cycle.
module lcd_ctrl #(
    parameter int PWR_CYC        = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 12,
    parameter int HOLD_CYC       = 4,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 80000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    // state       | meaning
    // ST_PWR_WAIT | power-on delay before the first init command
    // ST_SETUP    | RS/DATA driven, EN low
    // ST_EN_HI    | EN pulse
    // ST_HOLD     | EN low, RS/DATA held
    // ST_WAIT     | LCD execution time for the byte just written
    // ST_IDLE     | waiting for a request (rdy high from the second cycle on)

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_of(max_of(max_of(PWR_CYC, SETUP_CYC), max_of(EN_CYC, HOLD_CYC)),
                                    max_of(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] PWR_L   = CNT_W'(PWR_CYC);
    localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] EN_L    = CNT_W'(EN_CYC);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CMD_L   = CNT_W'(CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] CLEAR_L = CNT_W'(CLEAR_WAIT_CYC);
    localparam logic [CNT_W-1:0] TC_L    = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            default:          init_rom = 8'h06;
        endcase
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic             on_q, on_n;
    logic             en_q, en_n;
    logic             rs_q, rs_n;
    logic [7:0]       data_q, data_n;
    logic             rdy_q, rdy_n;
    logic             done_q, done_n;

    logic tc;
    logic accept;
    logic init_more;
    logic is_clear;

    assign tc        = (cnt == TC_L);
    assign accept    = (state == ST_IDLE) && rdy_q && i_req_vld;
    assign init_more = (idx != LAST_IDX);
    // Clear display and return home need the long execution wait.
    assign is_clear  = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_PWR_WAIT;
            cnt    <= PWR_L;
            idx    <= 3'd0;
            on_q   <= 1'b0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            on_q   <= on_n;
            en_q   <= en_n;
            rs_q   <= rs_n;
            data_q <= data_n;
            rdy_q  <= rdy_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt - TC_L;
        idx_n   = idx;
        case (state)
            ST_PWR_WAIT: if (tc) begin
                state_n = ST_SETUP;
                cnt_n   = SETUP_L;
            end
            ST_SETUP: if (tc) begin
                state_n = ST_EN_HI;
                cnt_n   = EN_L;
            end
            ST_EN_HI: if (tc) begin
                state_n = ST_HOLD;
                cnt_n   = HOLD_L;
            end
            ST_HOLD: if (tc) begin
                state_n = ST_WAIT;
                cnt_n   = is_clear ? CLEAR_L : CMD_L;
            end
            ST_WAIT: if (tc) begin
                if (init_more) begin
                    state_n = ST_SETUP;
                    cnt_n   = SETUP_L;
                    idx_n   = idx + 3'd1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_n = cnt;
                if (accept) begin
                    state_n = ST_SETUP;
                    cnt_n   = SETUP_L;
                end
            end
            default: begin
                state_n = ST_PWR_WAIT;
                cnt_n   = PWR_L;
            end
        endcase
    end

    // Output registers are loaded from the next-state decision so every pin is a flop.
    always_comb begin
        on_n   = on_q;
        rs_n   = rs_q;
        data_n = data_q;
        en_n   = (state_n == ST_EN_HI);
        rdy_n  = (state == ST_IDLE) && !accept;
        done_n = done_q || (state == ST_IDLE);
        if (state == ST_PWR_WAIT && tc) begin
            on_n   = 1'b1;
            rs_n   = 1'b0;
            data_n = init_rom(3'd0);
        end else if (state == ST_WAIT && tc && init_more) begin
            rs_n   = 1'b0;
            data_n = init_rom(idx + 3'd1);
        end else if (accept) begin
            rs_n   = i_req_rs;
            data_n = i_req_data;
        end
    end

    assign o_req_rdy   = rdy_q;
    assign o_init_done = done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected EN pulses and ready times are computed from the
// timing rules when stimulus is issued; a forked monitor checks what the LCD pins actually do.
module tb_lcd_ctrl;

    localparam int PWR = 20;
    localparam int S   = 2;
    localparam int E   = 4;
    localparam int H   = 2;
    localparam int CMD = 8;
    localparam int CLR = 30;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       vld   = 1'b0;
    logic       rs_in = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       rdy, done, on, en, rs, rw;
    logic [7:0] dq;

    lcd_ctrl #(
        .PWR_CYC(PWR), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
        .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(vld), .i_req_rs(rs_in), .i_req_data(din),
        .o_req_rdy(rdy), .o_init_done(done), .o_lcd_on(on), .o_lcd_en(en),
        .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_data(dq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         t;      // edge on which the byte is loaded (accept or init step)
    } xfer_t;

    xfer_t sb[$];
    int    rq[$];
    int    on_exp = 0;
    bit    mon_en = 1'b0;
    int    tot = 0;
    int    bad = 0;
    logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    task automatic chk(input string name, input int act, input int exp);
        tot++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int wait_of(input logic r, input logic [7:0] d);
        return (!r && d >= 8'h01 && d <= 8'h03) ? CLR : CMD;
    endfunction

    task automatic load_init(input int rel);
        int t;
        t      = rel + PWR;
        on_exp = t;
        for (int k = 0; k < 6; k++) begin
            sb.push_back('{1'b0, init_bytes[k], t});
            t += S + E + H + wait_of(1'b0, init_bytes[k]);
        end
        rq.push_back(t + 1);
    endtask

    task automatic monitor();
        logic       en_q = 1'b0;
        logic       rdy_q = 1'b0;
        logic       on_q = 1'b0;
        logic       stable = 1'b0;
        int         rise = 0;
        int         hold_left = 0;
        logic       hr [S];
        logic [7:0] hd [S];
        xfer_t      cur;
        cur = '{1'b0, 8'h00, 0};
        for (int i = 0; i < S; i++) begin
            hr[i] = 1'b0;
            hd[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                en_q = 1'b0; rdy_q = 1'b0; on_q = 1'b0; hold_left = 0;
                continue;
            end
            if (on && !on_q) chk("lcd_on_rise_cycle", cyc, on_exp);
            if (en && !en_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_en_pulse", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    chk("en_rise_cycle", cyc, cur.t + S);
                    chk("pulse_rs", int'(rs), int'(cur.rs));
                    chk("pulse_data", int'(dq), int'(cur.data));
                    chk("rw_low", int'(rw), 0);
                    stable = 1'b1;
                    for (int i = 0; i < S; i++)
                        if (hr[i] !== cur.rs || hd[i] !== cur.data) stable = 1'b0;
                    chk("setup_stable", int'(stable), 1);
                end
                stable = 1'b1;
                rise   = cyc;
            end
            if (en && (rs !== cur.rs || dq !== cur.data)) stable = 1'b0;
            if (!en && en_q) begin
                chk("en_width", cyc - rise, E);
                hold_left = H;
            end
            if (hold_left > 0) begin
                if (en || rs !== cur.rs || dq !== cur.data) stable = 1'b0;
                hold_left--;
                if (hold_left == 0) chk("pulse_hold_stable", int'(stable), 1);
            end
            if (rdy && !rdy_q) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rdy_rise", 1, 0);
                end else begin
                    int e;
                    e = rq.pop_front();
                    chk("rdy_rise_cycle", cyc, e);
                    chk("init_done_with_rdy", int'(done), 1);
                end
            end
            for (int i = S - 1; i > 0; i--) begin
                hr[i] = hr[i-1];
                hd[i] = hd[i-1];
            end
            hr[0] = rs;
            hd[0] = dq;
            en_q  = en;
            rdy_q = rdy;
            on_q  = on;
        end
    endtask

    task automatic send(input logic r, input logic [7:0] d);
        int n;
        n     = 0;
        vld   = 1'b1;
        rs_in = r;
        din   = d;
        @(negedge clk);
        while (!rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_budget", int'(rdy), 1);
        if (rdy) begin
            chk("init_done_at_accept", int'(done), 1);
            sb.push_back('{r, d, cyc + 1});
            rq.push_back(cyc + 1 + S + E + H + wait_of(r, d) + 1);
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rq.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size() + rq.size(), 0);
    endtask

    initial begin
        int n;
        int rel;
        logic       r;
        logic [7:0] d;
        fork
            monitor();
        join_none

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_init_done", int'(done), 0);
        chk("rst_lcd_on", int'(on), 0);
        chk("rst_lcd_en", int'(en), 0);
        chk("rst_lcd_rs", int'(rs), 0);
        chk("rst_lcd_rw", int'(rw), 0);
        chk("rst_lcd_data", int'(dq), 0);

        // A request pending from reset must wait for the whole init sequence.
        vld   = 1'b1;
        rs_in = 1'b1;
        din   = 8'h5A;
        rel   = cyc;
        rst_n = 1'b1;
        load_init(rel);
        mon_en = 1'b1;
        send(1'b1, 8'h5A);

        send(1'b1, 8'h41);
        send(1'b0, 8'h01);
        send(1'b1, 8'h01);
        send(1'b1, 8'h48);
        send(1'b1, 8'h49);

        for (int k = 0; k < 20; k++) begin
            r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 4));
            else                           d = 8'($urandom_range(0, 255));
            send(r, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        // Reset while EN is high: pins drop at once, then init restarts from scratch.
        mon_en = 1'b0;
        vld    = 1'b1;
        rs_in  = 1'b1;
        din    = 8'h77;
        n      = 0;
        while (!en && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("en_high_before_reset", int'(en), 1);
        vld = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_lcd_en", int'(en), 0);
        chk("midreset_lcd_on", int'(on), 0);
        chk("midreset_rdy", int'(rdy), 0);
        chk("midreset_init_done", int'(done), 0);
        sb.delete();
        rq.delete();
        @(negedge clk);
        @(negedge clk);
        rel   = cyc;
        rst_n = 1'b1;
        load_init(rel);
        mon_en = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
